// File: rtl/cam_capture_pkg.sv
// cam_capture_pkg: types and constants shared by the frame-capture controller.
//   cap_state_e   : controller states (IDLE, WAIT_VS, CAPTURE)
//   ERR_*         : bit positions inside the sticky ERR vector
//   addr_*        : field positions of the write address {bank, row, col}
package cam_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

  localparam int ERR_OVR   = 0;  // frame skipped because the target bank was still owned
  localparam int ERR_LONG  = 1;  // pixel beyond the line or frame geometry
  localparam int ERR_SHORT = 2;  // frame ended with fewer lines than expected
  localparam int ERR_W     = 3;

  // Write address layout, LSB first: col, then row, then the bank bit on top.
  localparam int ADDR_COL_LSB = 0;

  function automatic int addr_row_lsb(input int col_w);
    return col_w;
  endfunction

  function automatic int addr_bank_bit(input int row_w, input int col_w);
    return row_w + col_w;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: keeps a registered copy of a 1-bit level and reports its edges.
//   clk  : clock
//   rst  : synchronous active-high reset (clears the registered copy)
//   d    : level input, already synchronous to clk
//   rise : d is high now and was low last cycle (combinational)
//   fall : d is low now and was high last cycle (combinational)
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: turns the VSYNC/HSYNC/DATA pixel stream into write strobes
// for a two-bank (ping-pong) frame buffer and tracks bank ownership.
//   PCLK, RESET            : pixel clock, synchronous active-high reset
//   CAP_START/CONT/ABORT   : arm (also clears ERR), re-arm level, abort to IDLE
//   VSYNC, HSYNC, DATA_IN  : frame valid, pixel valid, pixel data
//   BANK_RELEASE, REL_BANK : consumer frees a bank
//   WR_EN/WR_ADDR/WR_DATA  : registered frame-buffer write, WR_ADDR = {bank,row,col}
//   FRAME_DONE, DONE_BANK  : completion pulse and the bank it refers to
//   BUSY, BANK_FULL        : not-IDLE flag, per-bank consumer ownership
//   FRAME_CNT, ERR         : completed-frame counter (wraps), sticky errors
//   dbg_state              : current controller state
//
// Handshake: there is no backpressure. A write is valid exactly in the cycle
// WR_EN is high; FRAME_DONE is a single-cycle pulse; BANK_RELEASE is a
// single-cycle pulse acted on in the cycle it is sampled high.
module cam_capture_ctrl
  import cam_capture_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int COL_WIDTH       = 10,
  parameter int ROW_WIDTH       = 9,
  parameter int PIX_PER_LINE    = 640,
  parameter int LINES_PER_FRAME = 480
) (
  input  logic                            PCLK,
  input  logic                            RESET,
  input  logic                            CAP_START,
  input  logic                            CAP_CONT,
  input  logic                            CAP_ABORT,
  input  logic                            VSYNC,
  input  logic                            HSYNC,
  input  logic [DATA_WIDTH-1:0]           DATA_IN,
  input  logic                            BANK_RELEASE,
  input  logic                            REL_BANK,
  output logic                            WR_EN,
  output logic [ROW_WIDTH+COL_WIDTH:0]    WR_ADDR,
  output logic [DATA_WIDTH-1:0]           WR_DATA,
  output logic                            FRAME_DONE,
  output logic                            DONE_BANK,
  output logic                            BUSY,
  output logic [1:0]                      BANK_FULL,
  output logic [15:0]                     FRAME_CNT,
  output logic [ERR_W-1:0]                ERR,
  output cap_state_e                      dbg_state
);

  localparam int ROW_LSB  = addr_row_lsb(COL_WIDTH);
  localparam int BANK_BIT = addr_bank_bit(ROW_WIDTH, COL_WIDTH);

  cap_state_e                  state, state_d;
  logic [ROW_WIDTH-1:0]        row, row_d, row_inc, row_end;
  logic [COL_WIDTH-1:0]        col, col_d, col_inc;
  logic                        act_bank, act_bank_d;
  logic                        vs_rise, vs_fall, hs_fall, unused_hs_rise;
  logic                        in_geometry;

  logic                        wr_en_d, done_d, done_bank_d, busy_d;
  logic [ROW_WIDTH+COL_WIDTH:0] wr_addr_d;
  logic [DATA_WIDTH-1:0]       wr_data_d;
  logic [1:0]                  bank_full_d;
  logic [15:0]                 frame_cnt_d;
  logic [ERR_W-1:0]            err_d;

  cam_sync_edge u_vs_edge (
    .clk  (PCLK),
    .rst  (RESET),
    .d    (VSYNC),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  cam_sync_edge u_hs_edge (
    .clk  (PCLK),
    .rst  (RESET),
    .d    (HSYNC),
    .rise (unused_hs_rise),
    .fall (hs_fall)
  );

  // Counters saturate so an oversized line or frame cannot wrap back into
  // valid coordinates and overwrite earlier pixels.
  assign row_inc = (row == '1) ? row : row + ROW_WIDTH'(1);
  assign col_inc = (col == '1) ? col : col + COL_WIDTH'(1);

  // Row count as it stands once a line end in this same cycle is counted, so
  // a last line whose HSYNC drops together with VSYNC is not called short.
  assign row_end = hs_fall ? row_inc : row;

  assign in_geometry = (32'(row) < LINES_PER_FRAME) && (32'(col) < PIX_PER_LINE);

  always_comb begin
    state_d     = state;
    row_d       = row;
    col_d       = col;
    act_bank_d  = act_bank;
    wr_en_d     = 1'b0;
    wr_addr_d   = WR_ADDR;
    wr_data_d   = WR_DATA;
    done_d      = 1'b0;
    done_bank_d = DONE_BANK;
    frame_cnt_d = FRAME_CNT;
    err_d       = ERR;
    bank_full_d = BANK_FULL;

    // Release first so a completion of the same bank below overrides it.
    if (BANK_RELEASE) begin
      bank_full_d[REL_BANK] = 1'b0;
    end

    if (CAP_ABORT) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CAP_START) begin
            state_d = ST_WAIT_VS;
            err_d   = '0;
          end
        end
        ST_WAIT_VS: begin
          if (vs_rise) begin
            if (BANK_FULL[act_bank]) begin
              err_d[ERR_OVR] = 1'b1;
            end else begin
              state_d = ST_CAPTURE;
              row_d   = '0;
              col_d   = '0;
            end
          end
        end
        ST_CAPTURE: begin
          if (HSYNC) begin
            if (in_geometry) begin
              wr_en_d                                = 1'b1;
              wr_addr_d                              = '0;
              wr_addr_d[BANK_BIT]                    = act_bank;
              wr_addr_d[ROW_LSB +: ROW_WIDTH]        = row;
              wr_addr_d[ADDR_COL_LSB +: COL_WIDTH]   = col;
              wr_data_d                              = DATA_IN;
            end else begin
              err_d[ERR_LONG] = 1'b1;
            end
            col_d = col_inc;
          end
          if (hs_fall) begin
            col_d = '0;
            row_d = row_inc;
          end
          if (vs_fall) begin
            done_d                = 1'b1;
            done_bank_d           = act_bank;
            bank_full_d[act_bank] = 1'b1;
            frame_cnt_d           = FRAME_CNT + 16'd1;
            act_bank_d            = ~act_bank;
            if (32'(row_end) < LINES_PER_FRAME) begin
              err_d[ERR_SHORT] = 1'b1;
            end
            state_d = CAP_CONT ? ST_WAIT_VS : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      row        <= '0;
      col        <= '0;
      act_bank   <= 1'b0;
      WR_EN      <= 1'b0;
      WR_ADDR    <= '0;
      WR_DATA    <= '0;
      FRAME_DONE <= 1'b0;
      DONE_BANK  <= 1'b0;
      BUSY       <= 1'b0;
      BANK_FULL  <= '0;
      FRAME_CNT  <= '0;
      ERR        <= '0;
    end else begin
      state      <= state_d;
      row        <= row_d;
      col        <= col_d;
      act_bank   <= act_bank_d;
      WR_EN      <= wr_en_d;
      WR_ADDR    <= wr_addr_d;
      WR_DATA    <= wr_data_d;
      FRAME_DONE <= done_d;
      DONE_BANK  <= done_bank_d;
      BUSY       <= busy_d;
      BANK_FULL  <= bank_full_d;
      FRAME_CNT  <= frame_cnt_d;
      ERR        <= err_d;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: self-checking bench for cam_capture_ctrl with a 4x3
// frame geometry. A frame-level reference model predicts every write, the
// bank bookkeeping, the frame counter and the error bits.
module tb_cam_capture_ctrl;
  import cam_capture_pkg::*;

  localparam int DW  = 16;
  localparam int CW  = 10;
  localparam int RW  = 9;
  localparam int PPL = 4;
  localparam int LPF = 3;
  localparam int AW  = 1 + RW + CW;
  localparam int W   = AW + DW;

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic RESET = 1'b1;
  always #5 PCLK = ~PCLK;

  logic          CAP_START = 1'b0, CAP_CONT = 1'b0, CAP_ABORT = 1'b0;
  logic          VSYNC = 1'b0, HSYNC = 1'b0;
  logic [DW-1:0] DATA_IN = '0;
  logic          BANK_RELEASE = 1'b0, REL_BANK = 1'b0;
  logic          WR_EN, FRAME_DONE, DONE_BANK, BUSY;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic [1:0]    BANK_FULL;
  logic [15:0]   FRAME_CNT;
  logic [2:0]    ERR;
  logic [1:0]    dbg_state;

  cam_capture_ctrl #(
    .DATA_WIDTH(DW), .COL_WIDTH(CW), .ROW_WIDTH(RW),
    .PIX_PER_LINE(PPL), .LINES_PER_FRAME(LPF)
  ) dut (
    .PCLK(PCLK), .RESET(RESET), .CAP_START(CAP_START), .CAP_CONT(CAP_CONT),
    .CAP_ABORT(CAP_ABORT), .VSYNC(VSYNC), .HSYNC(HSYNC), .DATA_IN(DATA_IN),
    .BANK_RELEASE(BANK_RELEASE), .REL_BANK(REL_BANK), .WR_EN(WR_EN),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .FRAME_DONE(FRAME_DONE),
    .DONE_BANK(DONE_BANK), .BUSY(BUSY), .BANK_FULL(BANK_FULL),
    .FRAME_CNT(FRAME_CNT), .ERR(ERR), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int wr_seen = 0;
  int done_seen = 0;

  // Reference model state (frame-level view of the controller).
  bit          m_armed, m_cont, m_cap, m_bank;
  bit   [1:0]  m_full;
  logic [15:0] m_cnt;
  logic [2:0]  m_err;
  int          m_row, m_done_exp;

  logic [W-1:0] exp_q[$];

  // Scoreboard: every write must match the next predicted {addr,data}.
  always @(negedge PCLK) begin
    logic [W-1:0] e;
    if (FRAME_DONE === 1'b1) done_seen++;
    if (WR_EN === 1'b1) begin
      wr_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", WR_ADDR, WR_DATA);
      end else begin
        e = exp_q.pop_front();
        if ({WR_ADDR, WR_DATA} !== e) begin
          n_errors++;
          $display("FAIL wr_match: got addr=%h data=%h, required addr=%h data=%h",
                   WR_ADDR, WR_DATA, e[W-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "time limit");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic model_clear();
    m_armed = 0; m_cont = CAP_CONT; m_cap = 0; m_bank = 0; m_full = '0;
    m_cnt = '0; m_err = '0; m_row = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    model_clear();
  endtask

  task automatic set_cont(input bit b);
    CAP_CONT = b;
    m_cont = b;
  endtask

  task automatic arm();
    CAP_START = 1'b1;
    tick();
    CAP_START = 1'b0;
    m_armed = 1;
    m_err = '0;
  endtask

  task automatic abort();
    CAP_ABORT = 1'b1;
    tick();
    CAP_ABORT = 1'b0;
    m_armed = 0;
    m_cap = 0;
  endtask

  task automatic release_bank(input int b);
    BANK_RELEASE = 1'b1;
    REL_BANK = b[0];
    tick();
    BANK_RELEASE = 1'b0;
    m_full[b] = 1'b0;
  endtask

  task automatic push_exp(input int r, input int c, input logic [DW-1:0] d);
    logic [AW-1:0] a;
    a = AW'((int'(m_bank) << (RW + CW)) + (r << CW) + c);
    exp_q.push_back({a, d});
  endtask

  task automatic vs_up();
    VSYNC = 1'b1;
    m_row = 0;
    m_cap = 0;
    if (m_armed) begin
      if (m_full[m_bank]) m_err[ERR_OVR] = 1'b1;
      else m_cap = 1;
    end
    tick();
    tick();
  endtask

  task automatic send_line(input int npix);
    for (int c = 0; c < npix; c++) begin
      HSYNC = 1'b1;
      DATA_IN = DW'($urandom);
      if (m_cap) begin
        if (m_row < LPF && c < PPL) push_exp(m_row, c, DATA_IN);
        else m_err[ERR_LONG] = 1'b1;
      end
      tick();
    end
    HSYNC = 1'b0;
    tick();
    tick();
    m_row++;
  endtask

  // rel >= 0 pulses BANK_RELEASE for that bank in the same cycle VSYNC drops.
  task automatic vs_down(input int rel);
    VSYNC = 1'b0;
    if (rel >= 0) begin
      BANK_RELEASE = 1'b1;
      REL_BANK = rel[0];
      m_full[rel] = 1'b0;
    end
    if (m_cap) begin
      m_done_exp++;
      m_full[m_bank] = 1'b1;
      m_cnt = m_cnt + 16'd1;
      if (m_row < LPF) m_err[ERR_SHORT] = 1'b1;
      m_bank = ~m_bank;
      m_armed = m_cont;
      m_cap = 0;
    end
    tick();
    BANK_RELEASE = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_frame(input int nlines, input int long_line, input int rel);
    vs_up();
    for (int l = 0; l < nlines; l++) send_line((l == long_line) ? PPL + 2 : PPL);
    vs_down(rel);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({WR_EN, FRAME_DONE, DONE_BANK, BUSY} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: WR_EN,FRAME_DONE,DONE_BANK,BUSY=%b required 0000",
               {WR_EN, FRAME_DONE, DONE_BANK, BUSY});
    end
    n_checks++;
    if ({WR_ADDR, WR_DATA, BANK_FULL, FRAME_CNT, ERR} !== '0) begin
      n_errors++;
      $display("FAIL reset_values: addr=%h data=%h full=%b cnt=%h err=%b required all 0",
               WR_ADDR, WR_DATA, BANK_FULL, FRAME_CNT, ERR);
    end
    n_checks++;
    if (dbg_state !== 2'(ST_IDLE)) begin
      n_errors++;
      $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
    end
    RESET = 1'b0;
    model_clear();
  endtask

  task automatic test_single_frame();
    int w0;
    do_reset();
    set_cont(0);
    arm();
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_errors++; $display("FAIL single_busy_rise: BUSY=%b required 1", BUSY);
    end
    w0 = wr_seen;
    run_frame(3, -1, -1);
    n_checks++;
    if (wr_seen - w0 !== 12 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL single_writes: writes=%0d pending=%0d required 12 and 0", wr_seen - w0, exp_q.size());
    end
    n_checks++;
    if (done_seen !== m_done_exp || DONE_BANK !== 1'b0) begin
      n_errors++;
      $display("FAIL single_done: pulses=%0d bank=%b required %0d and 0", done_seen, DONE_BANK, m_done_exp);
    end
    n_checks++;
    if (BANK_FULL !== 2'b01 || FRAME_CNT !== 16'd1) begin
      n_errors++;
      $display("FAIL single_full_cnt: full=%b cnt=%0d required 01 and 1", BANK_FULL, FRAME_CNT);
    end
    n_checks++;
    if (BUSY !== 1'b0 || dbg_state !== 2'(ST_IDLE)) begin
      n_errors++;
      $display("FAIL single_idle: BUSY=%b state=%0d required 0 and IDLE", BUSY, dbg_state);
    end
  endtask

  task automatic test_continuous();
    int w1;
    do_reset();
    set_cont(1);
    arm();
    run_frame(3, -1, -1);
    n_checks++;
    if (DONE_BANK !== 1'b0) begin
      n_errors++; $display("FAIL cont_bank0: DONE_BANK=%b required 0", DONE_BANK);
    end
    run_frame(3, -1, -1);
    n_checks++;
    if (DONE_BANK !== 1'b1) begin
      n_errors++; $display("FAIL cont_bank1: DONE_BANK=%b required 1", DONE_BANK);
    end
    w1 = wr_seen;
    run_frame(3, -1, -1);
    n_checks++;
    if (wr_seen !== w1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL cont_skip_writes: writes=%0d pending=%0d required 0 and 0", wr_seen - w1, exp_q.size());
    end
    n_checks++;
    if (ERR !== 3'b001 || FRAME_CNT !== 16'd2 || BANK_FULL !== 2'b11) begin
      n_errors++;
      $display("FAIL cont_overrun: err=%b cnt=%0d full=%b required 001, 2, 11", ERR, FRAME_CNT, BANK_FULL);
    end
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_errors++; $display("FAIL cont_busy: BUSY=%b required 1", BUSY);
    end
    set_cont(0);
    abort();
    release_bank(0);
    release_bank(1);
  endtask

  task automatic test_arm_mid_frame();
    int w0;
    set_cont(0);
    vs_up();
    arm();
    w0 = wr_seen;
    for (int l = 0; l < 3; l++) send_line(PPL);
    vs_down(-1);
    n_checks++;
    if (wr_seen !== w0 || ERR !== 3'b000 || BUSY !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_no_capture: writes=%0d err=%b busy=%b required 0, 000, 1", wr_seen - w0, ERR, BUSY);
    end
    run_frame(3, -1, -1);
    n_checks++;
    if (wr_seen - w0 !== 12 || exp_q.size() != 0 || done_seen !== m_done_exp) begin
      n_errors++;
      $display("FAIL mid_capture: writes=%0d pending=%0d done=%0d required 12, 0, %0d",
               wr_seen - w0, exp_q.size(), done_seen, m_done_exp);
    end
    release_bank(0);
    release_bank(1);
  endtask

  task automatic test_geometry();
    int w0, d0;
    set_cont(1);
    arm();
    w0 = wr_seen;
    run_frame(3, 1, -1);
    n_checks++;
    if (wr_seen - w0 !== 12 || exp_q.size() != 0 || ERR !== 3'b010) begin
      n_errors++;
      $display("FAIL geom_long: writes=%0d pending=%0d err=%b required 12, 0, 010", wr_seen - w0, exp_q.size(), ERR);
    end
    d0 = done_seen;
    run_frame(2, -1, -1);
    n_checks++;
    if (ERR !== 3'b110 || done_seen - d0 !== 1 || ERR !== m_err) begin
      n_errors++;
      $display("FAIL geom_short: err=%b done_pulses=%0d required 110 and 1", ERR, done_seen - d0);
    end
    set_cont(0);
    abort();
    release_bank(0);
    release_bank(1);
  endtask

  task automatic test_abort();
    int w0, d0;
    bit b0;
    b0 = m_bank;
    set_cont(0);
    arm();
    vs_up();
    w0 = wr_seen;
    d0 = done_seen;
    send_line(PPL);
    send_line(1);
    n_checks++;
    if (wr_seen - w0 !== 5) begin
      n_errors++; $display("FAIL abort_partial: writes=%0d required 5", wr_seen - w0);
    end
    abort();
    n_checks++;
    if (BUSY !== 1'b0 || dbg_state !== 2'(ST_IDLE) || BANK_FULL !== 2'b00) begin
      n_errors++;
      $display("FAIL abort_idle: busy=%b state=%0d full=%b required 0, IDLE, 00", BUSY, dbg_state, BANK_FULL);
    end
    vs_down(-1);
    n_checks++;
    if (done_seen !== d0) begin
      n_errors++; $display("FAIL abort_no_done: pulses=%0d required 0", done_seen - d0);
    end
    arm();
    run_frame(3, -1, -1);
    n_checks++;
    if (DONE_BANK !== b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL abort_bank_kept: DONE_BANK=%b pending=%0d required %b and 0", DONE_BANK, exp_q.size(), b0);
    end
    release_bank(0);
    release_bank(1);
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    set_cont(0);
    arm();
    vs_up();
    send_line(PPL);
    send_line(1);
    d0 = done_seen;
    RESET = 1'b1;
    tick();
    n_checks++;
    if ({WR_EN, FRAME_DONE, DONE_BANK, BUSY, WR_ADDR, WR_DATA, BANK_FULL, FRAME_CNT, ERR} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: en=%b addr=%h data=%h busy=%b full=%b cnt=%h err=%b required all 0",
               WR_EN, WR_ADDR, WR_DATA, BUSY, BANK_FULL, FRAME_CNT, ERR);
    end
    RESET = 1'b0;
    model_clear();
    vs_down(-1);
    n_checks++;
    if (done_seen !== d0 || BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_discard: pulses=%0d busy=%b required 0 and 0", done_seen - d0, BUSY);
    end
  endtask

  task automatic test_collision();
    set_cont(0);
    arm();
    vs_up();
    for (int l = 0; l < 3; l++) send_line(PPL);
    vs_down(0);
    n_checks++;
    if (BANK_FULL !== 2'b01 || DONE_BANK !== 1'b0 || BANK_FULL !== m_full) begin
      n_errors++;
      $display("FAIL collision_set_wins: full=%b bank=%b required 01 and 0", BANK_FULL, DONE_BANK);
    end
  endtask

  task automatic test_random();
    int nl;
    release_bank(0);
    release_bank(1);
    set_cont(1);
    arm();
    for (int f = 0; f < 10; f++) begin
      vs_up();
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) send_line($urandom_range(1, 6));
      vs_down(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1);
      if ($urandom_range(0, 1) == 1) release_bank($urandom_range(0, 1));
      n_checks++;
      if (FRAME_CNT !== m_cnt || BANK_FULL !== m_full || ERR !== m_err || BUSY !== m_armed) begin
        n_errors++;
        $display("FAIL random_frame%0d: cnt=%0d full=%b err=%b busy=%b required %0d %b %b %b",
                 f, FRAME_CNT, BANK_FULL, ERR, BUSY, m_cnt, m_full, m_err, m_armed);
      end
    end
    set_cont(0);
    abort();
    n_checks++;
    if (exp_q.size() != 0 || done_seen !== m_done_exp) begin
      n_errors++;
      $display("FAIL random_totals: pending=%0d done=%0d required 0 and %0d", exp_q.size(), done_seen, m_done_exp);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m_done_exp = 0;
    test_reset();
    test_single_frame();
    test_continuous();
    test_arm_mid_frame();
    test_geometry();
    test_abort();
    test_reset_mid_frame();
    test_collision();
    test_random();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
